// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select pins of a 4:1 mux stage.
// Optional forced release after MAX_HOLD cycles: define MUX_SEL_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 ||
      (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
    $error("mux_sel_arbiter: bad MAX_HOLD/CNT_W");
  end

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] last_q;
  logic       valid_q;
  logic [1:0] pick_d;
  logic       hold_exp;
  logic       rel;

  // First requester after the last owner, wrapping.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [1:0] idx;
    pick = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign pick_d = pick(req, last_q);

`ifdef MUX_SEL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;

  assign hold_exp = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign timeout  = to_q;

  // Hold counter: zero while idle, saturating count in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= (state_q == GRANT) && hold_exp;
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (~&cnt_q) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  assign hold_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Owner is sel_q; it gives up on done, on
  // dropping its request, or on hold expiry.
  assign rel = done | ~req[sel_q] | hold_exp;

  // Two-state grant FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= GRANT;
            gnt_q   <= 4'b0001 << pick_d;
            sel_q   <= pick_d;
            valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= sel_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign s0    = sel_q[1];
  assign s1    = sel_q[0];
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter.
// Timeout cases run when MUX_SEL_TIMEOUT_EN is defined.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  mux_sel_arbiter #(
    .MAX_HOLD(4),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .s0     (s0),
    .s1     (s1),
    .valid  (valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check grant, select and valid in one go.
  task automatic chk_out(
    input string      tag,
    input logic [3:0] eg,
    input logic [1:0] es,
    input logic       ev
  );
    chk({tag, ".gnt"}, {4'h0, gnt}, {4'h0, eg});
    chk({tag, ".sel"}, {6'h0, s0, s1}, {6'h0, es});
    chk({tag, ".valid"}, {7'h0, valid}, {7'h0, ev});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #3;
    chk_out("rst", 4'b0000, 2'd0, 1'b0);
    chk("rst.to", {7'h0, timeout}, 8'h00);
    rst_n = 1'b1;
    tick();

    // 1: single request, done release
    req = 4'b0001;
    tick();
    chk_out("t1.grant", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    tick();
    chk_out("t1.rel", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk_out("t1.idle", 4'b0000, 2'd0, 1'b0);

    // 2: rotation with everyone requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_g = 4'b0001 << (i % 4);
      chk_out($sformatf("t2.g%0d", i), exp_g,
              2'(i % 4), 1'b1);
      done = 1'b1;
      tick();
      chk_out($sformatf("t2.r%0d", i), 4'b0000,
              2'(i % 4), 1'b0);
      done = 1'b0;
    end

    // 3: owner drops request, no preemption
    do_reset();
    req = 4'b0110;
    tick();
    chk_out("t3.g1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0100;
    tick();
    chk_out("t3.rel", 4'b0000, 2'd1, 1'b0);
    tick();
    chk_out("t3.g2", 4'b0100, 2'd2, 1'b1);

    // 4: async reset mid-grant
    do_reset();
    req = 4'b1000;
    tick();
    chk_out("t4.g3", 4'b1000, 2'd3, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("t4.async", 4'b0000, 2'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk_out("t4.first", 4'b0001, 2'd0, 1'b1);

    // done while idle is ignored
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b0010;
    tick();
    chk_out("t4.idone", 4'b0010, 2'd1, 1'b1);

`ifdef MUX_SEL_TIMEOUT_EN
    // 5: forced release after 4 cycles
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("t5.h%0d", i), 4'b0001, 2'd0, 1'b1);
      chk($sformatf("t5.to%0d", i), {7'h0, timeout}, 8'h00);
    end
    tick();
    chk_out("t5.rel", 4'b0000, 2'd0, 1'b0);
    chk("t5.pulse", {7'h0, timeout}, 8'h01);
    tick();
    chk_out("t5.regnt", 4'b0001, 2'd0, 1'b1);
    chk("t5.toend", {7'h0, timeout}, 8'h00);
`else
    // 6: grant held indefinitely
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("t6.h%0d", i), 4'b0001, 2'd0, 1'b1);
      chk($sformatf("t6.to%0d", i), {7'h0, timeout}, 8'h00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
